// File: rtl/timer_bank_pkg.sv
// Shared register map for the timer bank: register indices and the bit
// positions of the CTRL and STATUS fields.
package timer_bank_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN      = 31;
  localparam int CTRL_ONESHOT = 30;
  localparam int CTRL_IRQEN   = 29;

  localparam int STAT_FLAG    = 0;
  localparam int STAT_RUNNING = 1;

endpackage

// File: rtl/timer_chan.sv
// One timer channel: prescaler, up-counter, sticky overflow flag and its
// CTRL/PERIOD fields, written through a decoded local write port.
module timer_chan
  import timer_bank_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int PSC_W = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_we,
  input  logic             period_we,
  input  logic             count_we,
  input  logic             status_we,
  input  logic             wr_en,
  input  logic             wr_oneshot,
  input  logic             wr_irq_en,
  input  logic [PSC_W-1:0] wr_scale,
  input  logic [CNT_W-1:0] wr_value,
  input  logic             wr_clear,
  output logic             en,
  output logic             oneshot,
  output logic             irq_en,
  output logic [PSC_W-1:0] scale,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] count,
  output logic             flag,
  output logic             ovf
);

  logic [PSC_W-1:0] psc;
  logic             tick;
  logic             at_period;
  logic             reload;
  logic             start;

  assign tick      = en && (psc == scale);
  // >= so that lowering PERIOD below the current count reloads on the next tick
  assign at_period = (count >= period);
  // A COUNT write in the same cycle suppresses the overflow entirely
  assign reload    = tick && at_period && !count_we;
  assign start     = ctrl_we && wr_en && !en;

  always_ff @(posedge clk) begin
    if (reset) begin
      en      <= 1'b0;
      oneshot <= 1'b0;
      irq_en  <= 1'b0;
      scale   <= '0;
      period  <= '0;
      count   <= '0;
      psc     <= '0;
      flag    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      ovf <= reload;

      // A CTRL write overrides the one-shot self-disable in the same cycle
      if (ctrl_we) begin
        en      <= wr_en;
        oneshot <= wr_oneshot;
        irq_en  <= wr_irq_en;
        scale   <= wr_scale;
      end else if (reload && oneshot) begin
        en <= 1'b0;
      end

      if (period_we) begin
        period <= wr_value;
      end

      if (count_we) begin
        count <= wr_value;
        psc   <= '0;
      end else if (start) begin
        count <= '0;
        psc   <= '0;
      end else if (tick) begin
        psc   <= '0;
        count <= at_period ? '0 : count + CNT_W'(1);
      end else if (en) begin
        psc <= psc + PSC_W'(1);
      end

      // Set beats write-1-to-clear when both land on the same edge
      if (reload) begin
        flag <= 1'b1;
      end else if (status_we && wr_clear) begin
        flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/timer_bank.sv
// Multi-channel prescaled timer bank on the data-memory I/O path: address
// decode, combinational register read mux and the combined interrupt line.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter  int N_CH   = 4,
  parameter  int CNT_W  = 16,
  parameter  int PSC_W  = 15,
  localparam int ADDR_W = 2 + $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [N_CH-1:0]   ovf,
  output logic              irq
);

  logic [1:0]       reg_sel;
  logic [31:0]      ch_sel;
  logic             wr_acc;
  logic             unused_wdata;

  logic             en_a     [N_CH];
  logic             os_a     [N_CH];
  logic             ie_a     [N_CH];
  logic             flag_a   [N_CH];
  logic [PSC_W-1:0] scale_a  [N_CH];
  logic [CNT_W-1:0] period_a [N_CH];
  logic [CNT_W-1:0] count_a  [N_CH];

  assign reg_sel      = addr[1:0];
  assign wr_acc       = sel && we;
  assign unused_wdata = ^wdata;

  // A single-channel build has no channel field in the address
  generate
    if (ADDR_W > 2) begin : g_ch_dec
      assign ch_sel = 32'(addr[ADDR_W-1:2]);
    end else begin : g_ch_one
      assign ch_sel = '0;
    end
  endgenerate

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_chan
      logic hit;
      assign hit = wr_acc && (ch_sel == 32'(i));

      timer_chan #(
        .CNT_W (CNT_W),
        .PSC_W (PSC_W)
      ) u_chan (
        .clk        (clk),
        .reset      (reset),
        .ctrl_we    (hit && (reg_sel == REG_CTRL)),
        .period_we  (hit && (reg_sel == REG_PERIOD)),
        .count_we   (hit && (reg_sel == REG_COUNT)),
        .status_we  (hit && (reg_sel == REG_STATUS)),
        .wr_en      (wdata[CTRL_EN]),
        .wr_oneshot (wdata[CTRL_ONESHOT]),
        .wr_irq_en  (wdata[CTRL_IRQEN]),
        .wr_scale   (wdata[PSC_W-1:0]),
        .wr_value   (wdata[CNT_W-1:0]),
        .wr_clear   (wdata[STAT_FLAG]),
        .en         (en_a[i]),
        .oneshot    (os_a[i]),
        .irq_en     (ie_a[i]),
        .scale      (scale_a[i]),
        .period     (period_a[i]),
        .count      (count_a[i]),
        .flag       (flag_a[i]),
        .ovf        (ovf[i])
      );
    end
  endgenerate

  // Out-of-range channel indices match no channel and read back as zero
  always_comb begin
    rdata = '0;
    if (sel) begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_sel == 32'(i)) begin
          case (reg_sel)
            REG_CTRL: begin
              rdata[CTRL_EN]      = en_a[i];
              rdata[CTRL_ONESHOT] = os_a[i];
              rdata[CTRL_IRQEN]   = ie_a[i];
              rdata[PSC_W-1:0]    = scale_a[i];
            end
            REG_PERIOD: rdata[CNT_W-1:0] = period_a[i];
            REG_COUNT:  rdata[CNT_W-1:0] = count_a[i];
            default: begin
              rdata[STAT_FLAG]    = flag_a[i];
              rdata[STAT_RUNNING] = en_a[i];
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    irq = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      irq = irq | (flag_a[i] & ie_a[i]);
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: directed scenarios with literal
// expectations plus randomized register traffic against a behavioural model.
module tb_timer_bank;

  localparam int N_CH  = 4;
  localparam int CNT_W = 16;
  localparam int PSC_W = 15;
  localparam int unsigned CMASK = (1 << CNT_W) - 1;
  localparam int unsigned PMASK = (1 << PSC_W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic            clk   = 1'b0;
  logic            reset = 1'b1;
  logic            sel   = 1'b0;
  logic            we    = 1'b0;
  logic [3:0]      addr  = '0;
  logic [31:0]     wdata = '0;
  logic [31:0]     rdata;
  logic [N_CH-1:0] ovf;
  logic            irq;

  logic            sel3   = 1'b0;
  logic            we3    = 1'b0;
  logic [3:0]      addr3  = '0;
  logic [31:0]     wdata3 = '0;
  logic [31:0]     rdata3;
  logic [2:0]      ovf3;
  logic            irq3;

  always #5 clk = ~clk;

  timer_bank #(.N_CH(N_CH), .CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
    .clk(clk), .reset(reset), .sel(sel), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ovf(ovf), .irq(irq)
  );

  timer_bank #(.N_CH(3), .CNT_W(CNT_W), .PSC_W(PSC_W)) dut3 (
    .clk(clk), .reset(reset), .sel(sel3), .we(we3), .addr(addr3),
    .wdata(wdata3), .rdata(rdata3), .ovf(ovf3), .irq(irq3)
  );

  // ---------------- scoreboard ----------------
  int          errors = 0;
  int          checks = 0;
  bit          chk_on = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit              m_en     [N_CH];
  bit              m_os     [N_CH];
  bit              m_ie     [N_CH];
  bit              m_flag   [N_CH];
  int unsigned     m_scale  [N_CH];
  int unsigned     m_period [N_CH];
  int unsigned     m_cnt    [N_CH];
  int unsigned     m_psc    [N_CH];
  logic [N_CH-1:0] m_ovf = '0;

  function automatic logic [31:0] model_rdata();
    int          ch;
    logic [31:0] v;
    v  = '0;
    ch = int'(addr[3:2]);
    if (sel) begin
      case (addr[1:0])
        2'd0: v = {m_en[ch], m_os[ch], m_ie[ch], 29'(m_scale[ch])};
        2'd1: v = m_period[ch];
        2'd2: v = m_cnt[ch];
        default: v = {30'd0, m_en[ch], m_flag[ch]};
      endcase
    end
    return v;
  endfunction

  function automatic logic model_irq();
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_CH; i++) r = r | (m_flag[i] & m_ie[i]);
    return r;
  endfunction

  // Advances the model across the coming rising edge using the inputs it will sample.
  task automatic model_step();
    logic [N_CH-1:0] nxt;
    nxt = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (reset) begin
        m_en[i] = 0; m_os[i] = 0; m_ie[i] = 0; m_flag[i] = 0;
        m_scale[i] = 0; m_period[i] = 0; m_cnt[i] = 0; m_psc[i] = 0;
      end else begin
        bit w, tick, at, ovf_now, was_en;
        int r;
        w       = sel && we && (int'(addr[3:2]) == i);
        r       = int'(addr[1:0]);
        was_en  = m_en[i];
        tick    = m_en[i] && (m_psc[i] == m_scale[i]);
        at      = m_cnt[i] >= m_period[i];
        ovf_now = tick && at && !(w && r == 2);
        if (m_en[i]) begin
          if (tick) begin
            m_psc[i] = 0;
            m_cnt[i] = at ? 0 : (m_cnt[i] + 1) & CMASK;
          end else begin
            m_psc[i] = (m_psc[i] + 1) & PMASK;
          end
        end
        if (ovf_now) begin
          m_flag[i] = 1;
          if (m_os[i]) m_en[i] = 0;
        end
        if (w) begin
          case (r)
            0: begin
              if (wdata[31] && !was_en) begin m_psc[i] = 0; m_cnt[i] = 0; end
              m_en[i] = wdata[31]; m_os[i] = wdata[30]; m_ie[i] = wdata[29];
              m_scale[i] = wdata & PMASK;
            end
            1: m_period[i] = wdata & CMASK;
            2: begin m_cnt[i] = wdata & CMASK; m_psc[i] = 0; end
            default: if (wdata[0] && !ovf_now) m_flag[i] = 0;
          endcase
        end
        nxt[i] = ovf_now;
      end
    end
    m_ovf = nxt;
  endtask

  // Compare the DUT to the model every cycle, then advance the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("rdata", rdata, model_rdata());
      check("ovf", 32'(ovf), 32'(m_ovf));
      check("irq", 32'(irq), 32'(model_irq()));
    end
    model_step();
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    sel = 0; we = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] r, input logic [31:0] d);
    sel = 1; we = 1; addr = {ch, r}; wdata = d;
    @(posedge clk); #1;
    sel = 0; we = 0;
  endtask

  task automatic rd(input logic [1:0] ch, input logic [1:0] r, output logic [31:0] d);
    sel = 1; we = 0; addr = {ch, r};
    @(negedge clk); d = rdata;
    @(posedge clk); #1;
    sel = 0;
  endtask

  task automatic wr3(input logic [1:0] ch, input logic [1:0] r, input logic [31:0] d);
    sel3 = 1; we3 = 1; addr3 = {ch, r}; wdata3 = d;
    @(posedge clk); #1;
    sel3 = 0; we3 = 0;
  endtask

  task automatic rd3(input logic [1:0] ch, input logic [1:0] r, output logic [31:0] d);
    sel3 = 1; we3 = 0; addr3 = {ch, r};
    @(negedge clk); d = rdata3;
    @(posedge clk); #1;
    sel3 = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    int          kind;

    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk_on = 1;
    @(negedge clk);
    check("reset_rdata", rdata, 32'h0);
    check("reset_ovf", 32'(ovf), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    @(posedge clk); #1;
    rd(2'd1, 2'd0, d); check("reset_ctrl1", d, 32'h0);
    rd(2'd3, 2'd1, d); check("reset_period3", d, 32'h0);

    // Channel 0: scale 1, period 3, periodic -> 8-cycle overflow
    wr(2'd0, 2'd1, 32'd3);
    wr(2'd0, 2'd0, 32'h8000_0001);
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(1);
    exp_q.push_back(2); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(3);
    sel = 1; addr = {2'd0, 2'd2};
    while (exp_q.size() > 0) begin
      @(negedge clk);
      check("ch0_count", rdata, exp_q.pop_front());
      check("ch0_ovf_quiet", 32'(ovf[0]), 32'h0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("ch0_ovf_pulse", 32'(ovf[0]), 32'h1);
    @(posedge clk); #1;
    sel = 0;

    // Channel 1: one-shot, scale 0, period 2 -> single overflow after 3 cycles
    wr(2'd1, 2'd1, 32'd2);
    wr(2'd1, 2'd0, 32'hC000_0000);
    idle(2);
    @(negedge clk); check("ch1_ovf_early", 32'(ovf[1]), 32'h0);
    idle(1);
    @(negedge clk); check("ch1_ovf_pulse", 32'(ovf[1]), 32'h1);
    rd(2'd1, 2'd3, d); check("ch1_status", d, 32'h1);
    rd(2'd1, 2'd2, d); check("ch1_count", d, 32'h0);

    // Channel 2: irq enable, W1C in a quiet cycle and on an overflow edge
    wr(2'd2, 2'd1, 32'd5);
    wr(2'd2, 2'd0, 32'hA000_0000);
    idle(6);
    @(negedge clk); check("ch2_irq_set", 32'(irq), 32'h1);
    wr(2'd2, 2'd3, 32'h1);
    @(negedge clk); check("ch2_irq_clr", 32'(irq), 32'h0);
    idle(4);
    wr(2'd2, 2'd3, 32'h1);
    @(negedge clk);
    check("ch2_w1c_vs_ovf", 32'(irq), 32'h1);
    check("ch2_ovf_pulse", 32'(ovf[2]), 32'h1);
    rd(2'd2, 2'd3, d); check("ch2_status", d, 32'h3);

    // Channel 3: PERIOD lowered below count, then COUNT load
    wr(2'd3, 2'd1, 32'd100);
    wr(2'd3, 2'd0, 32'h8000_0000);
    idle(10);
    wr(2'd3, 2'd1, 32'd5);
    @(negedge clk); check("ch3_no_ovf_yet", 32'(ovf[3]), 32'h0);
    idle(1);
    @(negedge clk); check("ch3_reload", 32'(ovf[3]), 32'h1);
    wr(2'd3, 2'd2, 32'h0000_1234);
    rd(2'd3, 2'd2, d); check("ch3_count_load", d, 32'h1234);

    // Randomized register traffic, checked every cycle against the model
    for (int n = 0; n < 3000; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 3) begin
        sel = 1; we = 0; addr = 4'($urandom_range(0, 15));
        @(posedge clk); #1;
        sel = 0;
      end else if (kind == 3) begin
        sel = 0; we = 1; addr = 4'($urandom_range(0, 15)); wdata = $urandom;
        @(posedge clk); #1;
        we = 0;
      end else begin
        logic [1:0]  ch, r;
        logic [31:0] junk;
        ch   = 2'($urandom_range(0, 3));
        r    = 2'($urandom_range(0, 3));
        junk = $urandom;
        case (r)
          2'd0: d = {junk[31:29], junk[28:15], 13'd0, 2'($urandom_range(0, 3))};
          2'd1: d = {junk[31:16], 16'($urandom_range(0, 6))};
          2'd2: d = {junk[31:16], 16'($urandom_range(0, 8))};
          default: d = junk;
        endcase
        wr(ch, r, d);
      end
    end
    idle(2);

    // Reset while every channel is running mid-count
    for (int c = 0; c < N_CH; c++) begin
      wr(2'(c), 2'd1, (c == 2) ? 32'd0 : 32'd50);
      wr(2'(c), 2'd2, 32'd0);
      wr(2'(c), 2'd0, 32'hA000_0000);
    end
    idle(3);
    @(negedge clk); check("irq_pre_reset", 32'(irq), 32'h1);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    check("post_reset_ovf", 32'(ovf), 32'h0);
    check("post_reset_irq", 32'(irq), 32'h0);
    check("post_reset_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    for (int c = 0; c < N_CH; c++) begin
      for (int r = 0; r < 4; r++) begin
        rd(2'(c), 2'(r), d);
        check($sformatf("post_reset_reg_c%0d_r%0d", c, r), d, 32'h0);
      end
    end

    // Three-channel build: channel index 3 is out of range
    wr3(2'd0, 2'd1, 32'd7);
    wr3(2'd3, 2'd1, 32'hFFFF);
    wr3(2'd3, 2'd0, 32'h8000_0003);
    rd3(2'd3, 2'd1, d); check("n3_oor_period", d, 32'h0);
    rd3(2'd3, 2'd0, d); check("n3_oor_ctrl", d, 32'h0);
    rd3(2'd0, 2'd1, d); check("n3_ch0_period", d, 32'h7);
    rd3(2'd1, 2'd1, d); check("n3_ch1_period", d, 32'h0);
    rd3(2'd2, 2'd0, d); check("n3_ch2_ctrl", d, 32'h0);
    @(negedge clk); check("n3_irq", 32'(irq3), 32'h0);

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
# timer_bank

Parametrised multi-channel successor to the single free-running timer. It provides N_CH independent prescaled up-counters, each with periodic or one-shot mode, a sticky overflow flag with write-1-to-clear, a per-channel interrupt enable and a combined interrupt line. It sits on the data-memory I/O path behind the I/O address decoder, next to the RAM and UARTs. Its register file is read combinationally, so the single-cycle core sees load data in the same cycle.

## Interface
- N_CH, 4, number of timer channels (1..16)
- CNT_W, 16, counter and period width (1..32)
- PSC_W, 15, prescaler width (1..29)
- ADDR_W, derived localparam, 2 + clog2(N_CH), word-address width
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high; clears all state
- sel  in  1  block selected by I/O decoder
- we  in  1  write strobe, qualified by sel
- addr  in  ADDR_W  word address; [1:0] register, [ADDR_W-1:2] channel
- wdata  in  32  write data
- rdata  out  32  combinational read data, 0 when sel=0
- ovf  out  N_CH  one-cycle overflow pulse per channel
- irq  out  1  OR over channels of (flag & irq_en)

## Operation
- Registers per channel, selected by reg index:
  - 0 CTRL: [31] en, [30] oneshot, [29] irq_en, [PSC_W-1:0] scale.
  - 1 PERIOD: [CNT_W-1:0].
  - 2 COUNT: read current count; a write loads it.
  - 3 STATUS: [0] flag (W1C), [1] running = en (read-only).
- Unused bits read 0. Channel index >= N_CH: reads 0, writes ignored.
- Prescaler psc counts 0..scale. tick = en & (psc == scale); on tick psc wraps to 0. scale=0 gives a tick every cycle.
- On tick:
  - If cnt >= PERIOD (>= rather than ==, so a PERIOD lowered below cnt reloads immediately): cnt <= 0, ovf pulse, flag <= 1; if oneshot, en <= 0.
  - Otherwise cnt <= cnt + 1.
- PERIOD=0: overflow on every tick.
- CTRL write with en 0->1: psc <= 0, cnt <= 0. CTRL write keeping en=1: fields update, counters untouched. en=0: psc and cnt hold.
- COUNT write: cnt <= wdata[CNT_W-1:0], psc <= 0. It takes priority over the tick increment and reload in the same cycle, and no ovf is produced in that cycle.
- STATUS write: flag cleared where wdata[0]=1. If an overflow occurs in the same cycle, set wins and flag stays 1.
- Oneshot overflow coinciding with a CTRL write setting en=1: the write wins and the channel restarts from 0.

## Timing
- Reset: all CTRL, PERIOD, cnt, psc, flag = 0; ovf = 0; irq = 0; rdata = 0 with sel low.
- Writes take effect at the clk edge where sel & we is high. rdata reflects pre-edge state in the same cycle.
- ovf[i] is registered: high for exactly the one cycle following the reload edge.
- flag is visible in STATUS and irq in that same cycle.
- Overflow period = (scale+1)*(PERIOD+1) clk cycles after enable.
- reset asserted mid-count aborts everything in the next cycle; no ovf is emitted.

## Structure
- Shared package holds:
  - register index constants (REG_CTRL=0, REG_PERIOD=1, REG_COUNT=2, REG_STATUS=3);
  - CTRL bit positions (EN=31, ONESHOT=30, IRQEN=29);
  - STATUS bit positions.
- Sub-module timer_chan: one channel's psc, cnt, flag, CTRL and PERIOD, with a local write port and count/flag outputs. It is generated N_CH times.
- Top level does address decode, read mux and the irq OR.

## Test plan
- Channel 0: scale=1, PERIOD=3, periodic, en -> ovf[0] pulses every 8 cycles, first 8 cycles after enable; cnt reads 0,0,1,1,2,2,3,3.
- Channel 1: oneshot, scale=0, PERIOD=2 -> single ovf[1] after 3 cycles; STATUS reads 0x1 (running=0); cnt stays 0.
- irq_en=1 on channel 2 with overflow -> irq=1. Writing STATUS 0x1 in a non-overflow cycle -> irq=0 next cycle. W1C coinciding with an overflow -> flag stays 1.
- Channel 3 running at cnt=10: write PERIOD=5 -> reload at next tick, ovf pulse. Write COUNT=0x1234 -> next read 0x1234.
- reset asserted with all channels running mid-count -> all registers read 0, no ovf, irq=0 in the following cycle.
- Read addr for channel N_CH (N_CH=3 build) -> rdata=0. Write ignored: other channels' registers unchanged.
